bus_arb_to: RTL and testbench

BUS_ARB_TO -- requirements
Module: bus_arb_to

---
 rtl/bus_arb_to_pkg.sv | 15 +
 rtl/bus_arb_to_rr_pick.sv | 32 +++
 rtl/bus_arb_to.sv | 153 +++++++++++++++
 tb/tb_bus_arb_to.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_to_pkg.sv
// Shared types and constants for the round-robin bus arbiter with ack timeout.
package bus_arb_to_pkg;

    // IDLE: bus unowned, arbitrating. OWN: granted master drives the bus.
    // ERR: timed-out owner keeps its grant but the bus is parked until it drops cyc.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_ERR  = 2'd2
    } arb_state_t;

    localparam logic [27:0] TO_DEFAULT = 28'd250;
    localparam logic [27:0] CNT_RELOAD = 28'd1;

endpackage

// File: rtl/bus_arb_to_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer,
// searching upward and wrapping. Returns a one-hot grant and its index.
module bus_arb_to_rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [PW-1:0]   o_idx,
    output logic            o_any
);

    logic [PW-1:0] w_k;

    // Walk the requesters starting at the pointer; the first hit wins.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_k   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_k = PW'((int'(i_ptr) + i) % NREQ);
            if (!o_any && i_req[w_k]) begin
                o_any      = 1'b1;
                o_gnt[w_k] = 1'b1;
                o_idx      = w_k;
            end
        end
    end

endmodule

// File: rtl/bus_arb_to.sv
// Round-robin arbiter for NREQ bus masters onto one shared slave bus, with a
// per-strobe ack timeout that reports an error to the owning master.
//
//   state | meaning
//   IDLE  | bus unowned; pick next requester at/after pointer
//   OWN   | granted master muxed onto bus, ack/timeout routed to it
//   ERR   | owner timed out; grant held, bus parked until owner drops cyc
module bus_arb_to
    import bus_arb_to_pkg::*;
#(
    parameter int          NREQ = 4,
    parameter logic [27:0] pTO  = TO_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NREQ-1:0]      cyc_i,
    input  logic [NREQ-1:0]      stb_i,
    input  logic [NREQ-1:0]      we_i,
    input  logic [NREQ*32-1:0]   adr_i,
    input  logic [NREQ*32-1:0]   dat_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ-1:0]      ack_o,
    output logic [NREQ-1:0]      err_o,
    output logic [31:0]          dat_o,
    output logic                 m_cyc_o,
    output logic                 m_stb_o,
    output logic                 m_we_o,
    output logic [31:0]          m_adr_o,
    output logic [31:0]          m_dat_o,
    input  logic                 m_ack_i,
    input  logic [31:0]          m_dat_i
);

    localparam int PW = $clog2(NREQ);

    arb_state_t      r_state, w_state_nxt;
    logic [NREQ-1:0] r_gnt, w_gnt_nxt;
    logic [PW-1:0]   r_gidx, w_gidx_nxt;
    logic [PW-1:0]   r_ptr, w_ptr_nxt;
    logic [27:0]     r_cnt, w_cnt_nxt;

    logic [NREQ-1:0] w_pick_gnt;
    logic [PW-1:0]   w_pick_idx;
    logic            w_pick_any;
    logic [PW-1:0]   w_ptr_after;
    logic            w_own;
    logic            w_timeout;
    logic            w_g_cyc, w_g_stb, w_g_we;
    logic [31:0]     w_g_adr, w_g_dat;

    bus_arb_to_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .i_req (cyc_i),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    // Select the granted master's bus signals; all zero when nobody is granted.
    always_comb begin
        w_g_cyc = 1'b0;
        w_g_stb = 1'b0;
        w_g_we  = 1'b0;
        w_g_adr = '0;
        w_g_dat = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (r_gnt[k]) begin
                w_g_cyc = cyc_i[k];
                w_g_stb = stb_i[k];
                w_g_we  = we_i[k];
                w_g_adr = adr_i[32*k +: 32];
                w_g_dat = dat_i[32*k +: 32];
            end
        end
    end

    assign w_own       = (r_state == ST_OWN);
    assign w_ptr_after = (r_gidx == PW'(NREQ - 1)) ? '0 : r_gidx + PW'(1);

    assign m_cyc_o = w_own & w_g_cyc;
    assign m_stb_o = w_own & w_g_stb;
    assign m_we_o  = w_g_we;
    assign m_adr_o = w_g_adr;
    assign m_dat_o = w_g_dat;
    assign dat_o   = m_dat_i;
    assign gnt_o   = r_gnt;

    // A same-cycle ack beats the timeout, so ack is excluded here.
    assign w_timeout = m_cyc_o && m_stb_o && !m_ack_i && (r_cnt == pTO);
    assign ack_o     = w_own ? (r_gnt & {NREQ{m_ack_i}}) : '0;
    assign err_o     = w_timeout ? r_gnt : '0;

    // Stall counter restarts whenever the owner is not waiting on an ack; saturates at pTO.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (m_ack_i || !m_stb_o || !w_own) begin
            w_cnt_nxt = CNT_RELOAD;
        end else if (r_cnt < pTO) begin
            w_cnt_nxt = r_cnt + 28'd1;
        end
    end

    // Next-state logic: arbitrate in IDLE, hold the grant until the owner drops cyc.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_gidx_nxt  = r_gidx;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_gnt_nxt   = w_pick_gnt;
                    w_gidx_nxt  = w_pick_idx;
                    w_state_nxt = ST_OWN;
                end
            end
            ST_OWN, ST_ERR: begin
                if (!w_g_cyc) begin
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = w_ptr_after;
                    w_state_nxt = ST_IDLE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_ERR;
                end
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, grant, pointer and stall counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_gidx  <= '0;
            r_ptr   <= '0;
            r_cnt   <= CNT_RELOAD;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_gidx  <= w_gidx_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_bus_arb_to.sv
// Scoreboard bench for bus_arb_to: a round-robin/timeout reference model pushes
// expected grants, acks and errors; a negedge monitor pops and compares them.
module tb_bus_arb_to;

    localparam int NREQ = 4;
    localparam int TO   = 250;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic [NREQ-1:0]      cyc_i, stb_i, we_i;
    logic [NREQ*32-1:0]   adr_i, dat_i;
    logic [NREQ-1:0]      gnt_o, ack_o, err_o;
    logic [31:0]          dat_o;
    logic                 m_cyc_o, m_stb_o, m_we_o;
    logic [31:0]          m_adr_o, m_dat_o;
    logic                 m_ack_i;
    logic [31:0]          m_dat_i;

    bus_arb_to #(
        .NREQ (NREQ),
        .pTO  (28'd250)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .cyc_i   (cyc_i),
        .stb_i   (stb_i),
        .we_i    (we_i),
        .adr_i   (adr_i),
        .dat_i   (dat_i),
        .gnt_o   (gnt_o),
        .ack_o   (ack_o),
        .err_o   (err_o),
        .dat_o   (dat_o),
        .m_cyc_o (m_cyc_o),
        .m_stb_o (m_stb_o),
        .m_we_o  (m_we_o),
        .m_adr_o (m_adr_o),
        .m_dat_o (m_dat_o),
        .m_ack_i (m_ack_i),
        .m_dat_i (m_dat_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc_n = 0;
    always @(posedge clk_i) cyc_n <= cyc_n + 1;

    typedef struct {
        logic [NREQ-1:0] g;
        int              at;
    } ev_t;

    typedef struct {
        logic [NREQ-1:0] g;
        logic [31:0]     adr;
        logic [31:0]     wd;
        logic [31:0]     rd;
        logic            we;
    } ack_t;

    ev_t  gq[$];
    ev_t  eq[$];
    ack_t aq[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    function automatic logic [NREQ-1:0] oh(input int k);
        return NREQ'(1) << k;
    endfunction

    // Reference arbitration: first pending master at or after the pointer, wrapping.
    function automatic int pick(input logic [NREQ-1:0] req, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if ((req & oh((p + i) % NREQ)) != '0) return (p + i) % NREQ;
        end
        return 0;
    endfunction

    function automatic logic [NREQ-1:0] rand_nz();
        logic [NREQ-1:0] m;
        m = NREQ'($urandom());
        while (m == '0) m = NREQ'($urandom());
        return m;
    endfunction

    // Monitor: compare whatever the DUT presents against the scoreboard queues.
    logic [NREQ-1:0] prev_gnt = '0;
    always @(negedge clk_i) begin
        ev_t  e;
        ack_t a;
        if (gnt_o != '0 && prev_gnt == '0) begin
            if (gq.size() == 0) check("unexpected_grant", gnt_o, 0);
            else begin
                e = gq.pop_front();
                check("grant", gnt_o, e.g);
                check("grant_cycle", cyc_n, e.at);
            end
        end else if (gnt_o != '0 && gnt_o != prev_gnt) begin
            check("grant_preempted", gnt_o, prev_gnt);
        end
        if (err_o != '0) begin
            if (eq.size() == 0) check("unexpected_err", err_o, 0);
            else begin
                e = eq.pop_front();
                check("err", err_o, e.g);
                check("err_cycle", cyc_n, e.at);
            end
        end
        if (ack_o != '0) begin
            if (aq.size() == 0) check("unexpected_ack", ack_o, 0);
            else begin
                a = aq.pop_front();
                check("ack", ack_o, a.g);
                check("ack_adr", m_adr_o, a.adr);
                check("ack_wdat", m_dat_o, a.wd);
                check("ack_we", m_we_o, a.we);
                check("ack_cyc", m_cyc_o, 1);
                check("ack_stb", m_stb_o, 1);
                check("ack_rdat", dat_o, a.rd);
                check("ack_no_err", err_o, 0);
            end
        end
        prev_gnt <= gnt_o;
    end

    int              ptr_m;
    logic [NREQ-1:0] pending;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One strobe by owner w; d = cycle of ack (1 = same cycle), d = 0 = slave never acks.
    task automatic do_strobe(input int w, input int d, input logic wr);
        ack_t a;
        for (int k = 0; k < NREQ; k++) begin
            adr_i[32*k +: 32] = $urandom();
            dat_i[32*k +: 32] = $urandom();
        end
        stb_i = NREQ'($urandom()) | oh(w);
        we_i  = wr ? (NREQ'($urandom()) | oh(w)) : (NREQ'($urandom()) & ~oh(w));
        if (d == 0) begin
            eq.push_back('{g: oh(w), at: cyc_n + TO - 1});
            repeat (TO + 2) tick();
            check("err_mcyc_low", m_cyc_o, 0);
            check("err_mstb_low", m_stb_o, 0);
            check("err_gnt_held", gnt_o, oh(w));
        end else begin
            repeat (d - 1) tick();
            m_ack_i = 1'b1;
            m_dat_i = $urandom();
            a.g   = oh(w);
            a.adr = adr_i[32*w +: 32];
            a.wd  = dat_i[32*w +: 32];
            a.we  = wr;
            a.rd  = m_dat_i;
            aq.push_back(a);
            tick();
            m_ack_i = 1'b0;
            stb_i   = '0;
        end
    endtask

    // One ownership: arbitrate from idle, run up to three strobes, release.
    task automatic run_round(input logic [NREQ-1:0] raise, input logic [NREQ-1:0] extra,
                             input int nst, input int d0, input int d1, input int d2,
                             input int wmode);
        int   w;
        int   dl[3];
        logic wr;
        dl[0] = d0;
        dl[1] = d1;
        dl[2] = d2;
        if (pending == '0) pending = (raise != '0) ? raise : rand_nz();
        cyc_i = pending;
        w = pick(pending, ptr_m);
        gq.push_back('{g: oh(w), at: cyc_n + 1});
        tick();
        pending = pending | (extra & ~oh(w));
        cyc_i   = pending;
        for (int s = 0; s < nst; s++) begin
            wr = (wmode < 0) ? 1'($urandom_range(0, 1)) : wmode[0];
            do_strobe(w, dl[s], wr);
            if (dl[s] == 0) break;
            repeat ($urandom_range(0, 1)) tick();
        end
        pending = pending & ~oh(w);
        cyc_i   = pending;
        stb_i   = '0;
        ptr_m   = (w + 1) % NREQ;
        tick();
        check("idle_gnt", gnt_o, 0);
        check("idle_mcyc", m_cyc_o, 0);
    endtask

    initial begin
        int w;
        cyc_i   = '0;
        stb_i   = '0;
        we_i    = '0;
        adr_i   = '0;
        dat_i   = '0;
        m_ack_i = 1'b0;
        m_dat_i = '0;
        pending = '0;
        ptr_m   = 0;
        rst_ni  = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_gnt", gnt_o, 0);
        check("rst_mcyc", m_cyc_o, 0);
        check("rst_mstb", m_stb_o, 0);
        check("rst_ack", ack_o, 0);
        check("rst_err", err_o, 0);
        rst_ni = 1'b1;

        run_round(4'b0101, 4'b0000, 1, 3, 0, 0, -1);   // 0 and 2 together: 0 first
        run_round(4'b0000, 4'b1000, 1, 1, 0, 0, -1);   // 2 next, 3 arrives meanwhile
        run_round(4'b0000, 4'b0011, 1, 2, 0, 0, -1);   // 3 owns, 0 and 1 wait
        run_round(4'b0000, 4'b0000, 1, 4, 0, 0, -1);   // wrap to 0
        run_round(4'b0000, 4'b0000, 3, 5, 10, 20, 1);  // 1 does three writes
        run_round(4'b0100, 4'b0000, 1, 0, 0, 0, -1);   // 2 stalls to timeout
        run_round(4'b1000, 4'b0000, 1, TO, 0, 0, -1);  // ack exactly at pTO

        for (int r = 0; r < 24; r++) begin
            int              n;
            int              d[3];
            int              sel;
            logic [NREQ-1:0] ex;
            n = $urandom_range(1, 3);
            for (int s = 0; s < 3; s++) begin
                sel  = $urandom_range(0, 9);
                d[s] = (sel == 0) ? 0 : (sel == 1) ? TO : $urandom_range(1, 12);
            end
            ex = ($urandom_range(0, 2) == 0) ? NREQ'($urandom()) : '0;
            run_round('0, ex, n, d[0], d[1], d[2], -1);
        end

        // Reset in the middle of a stalled strobe.
        if (pending == '0) pending = oh($urandom_range(0, NREQ - 1));
        cyc_i = pending;
        w = pick(pending, ptr_m);
        gq.push_back('{g: oh(w), at: cyc_n + 1});
        tick();
        stb_i = oh(w);
        repeat (5) tick();
        #2;
        rst_ni = 1'b0;
        #1;
        check("midrst_gnt", gnt_o, 0);
        check("midrst_mcyc", m_cyc_o, 0);
        check("midrst_mstb", m_stb_o, 0);
        check("midrst_err", err_o, 0);
        check("midrst_ack", ack_o, 0);
        cyc_i   = '0;
        stb_i   = '0;
        pending = '0;
        ptr_m   = 0;
        tick();
        tick();
        rst_ni = 1'b1;
        run_round(4'b0100, 4'b0000, 1, 2, 0, 0, -1);

        repeat (3) tick();
        check("grant_q_drained", gq.size(), 0);
        check("err_q_drained", eq.size(), 0);
        check("ack_q_drained", aq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
